// File: rtl/picture_sender_pkg.sv
// Purpose: shared types and helpers for the picture_sender image UART streamer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package picture_sender_pkg;

    localparam int PIXEL_W = 18;
    localparam int ADDR_W  = 19;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        LATCH  = 3'd3,
        SEND_R = 3'd4,
        SEND_G = 3'd5,
        SEND_B = 3'd6,
        FINISH = 3'd7
    } state_t;

    // A 6-bit colour channel goes on the wire left-justified in a byte.
    function automatic logic [7:0] chan_to_byte(input logic [5:0] chan);
        return {chan, 2'b00};
    endfunction

endpackage

// File: rtl/picture_sender_uart_tx_byte.sv
// Purpose: 8N1 serializer, one byte per tx_load, LSB first.
// Latency: start bit begins 1 clk after tx_load; tx_done pulses in the last clk of the stop bit.
// Backpressure: tx_load accepted when idle or in the tx_done cycle (back-to-back frames, no gap).
//
// Ports: clk, resetn (async active-low), tx_byte/tx_load (byte to send),
//        uart_tx (serial line, idles high), tx_busy (frame in flight), tx_done (end of stop bit).
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_byte,
    input  logic       tx_load,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             busy_q;
    logic [CNT_W-1:0] baud_q;
    logic [3:0]       bit_q;      // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             bit_end;
    logic             accept;

    assign bit_end = (baud_q == BAUD_LAST);
    assign tx_done = busy_q && bit_end && (bit_q == 4'd9);
    // Accepting in the done cycle lets the next start bit follow the stop bit directly.
    assign accept  = tx_load && (!busy_q || tx_done);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q  <= 1'b0;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else if (accept) begin
            busy_q  <= 1'b1;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            shift_q <= tx_byte;
            tx_q    <= 1'b0;
        end else if (busy_q) begin
            if (bit_end) begin
                baud_q <= '0;
                if (bit_q == 4'd9) begin
                    busy_q <= 1'b0;
                    tx_q   <= 1'b1;
                end else begin
                    bit_q <= bit_q + 4'd1;
                    if (bit_q < 4'd8) begin
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
            end else begin
                baud_q <= baud_q + CNT_W'(1);
            end
        end
    end

    assign uart_tx = tx_q;
    assign tx_busy = busy_q;

endmodule

// File: rtl/picture_sender.sv
// Purpose: streams a stored 18-bit RGB picture over UART as 3 bytes per pixel, row-major.
// Latency: first start bit 5 clks after start is sampled; 4 idle clks between pixels.
// Backpressure: none; start is ignored while a transfer is in progress.
//
// Ports: clk, resetn (async active-low), start (one-cycle request),
//        rd_addr/rd_data (picture memory, data 1 clk after address),
//        uart_tx (8N1 line), busy (transfer in progress), done (end-of-image pulse).
module picture_sender #(
    parameter int H_SIZE    = 607,
    parameter int V_SIZE    = 455,
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 1_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic [18:0] rd_addr,
    input  logic [17:0] rd_data,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    import picture_sender_pkg::*;

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_SIZE * V_SIZE - 1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q;
    logic [PIXEL_W-1:0]   pix_q;
    logic                 addr_clr, addr_inc, pix_en;
    logic                 tx_load;
    logic [7:0]           tx_byte;
    logic                 ser_busy, ser_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            if (addr_clr)
                addr_q <= '0;
            else if (addr_inc)
                addr_q <= addr_q + ADDR_W'(1);
            if (pix_en)
                pix_q <= rd_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_clr = 1'b0;
        addr_inc = 1'b0;
        pix_en   = 1'b0;
        tx_load  = 1'b0;
        tx_byte  = 8'h00;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = FETCH;
                    addr_clr = 1'b1;
                end
            end
            FETCH: state_d = WAIT;
            WAIT:  state_d = LATCH;
            LATCH: begin
                pix_en  = 1'b1;
                state_d = SEND_R;
            end
            SEND_R: begin
                // The first cycle here is the load cycle; the G byte is handed over
                // in the R stop-bit's last clk so the frames abut.
                if (!ser_busy) begin
                    tx_load = 1'b1;
                    tx_byte = chan_to_byte(pix_q[17:12]);
                end else if (ser_done) begin
                    tx_load = 1'b1;
                    tx_byte = chan_to_byte(pix_q[11:6]);
                    state_d = SEND_G;
                end
            end
            SEND_G: begin
                if (ser_done) begin
                    tx_load = 1'b1;
                    tx_byte = chan_to_byte(pix_q[5:0]);
                    state_d = SEND_B;
                end
            end
            SEND_B: begin
                if (ser_done) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = FINISH;
                    end else begin
                        addr_inc = 1'b1;
                        state_d  = FETCH;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The address counter only moves on entry to FETCH, so it doubles as rd_addr
    // and naturally holds outside FETCH.
    assign rd_addr = addr_q;
    assign busy    = (state_q != IDLE) && (state_q != FINISH);
    assign done    = (state_q == FINISH);

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk     (clk),
        .resetn  (resetn),
        .tx_byte (tx_byte),
        .tx_load (tx_load),
        .uart_tx (uart_tx),
        .tx_busy (ser_busy),
        .tx_done (ser_done)
    );

endmodule

// File: tb/tb_picture_sender.sv
// Purpose: self-checking bench for picture_sender with a 2x2 image at 4 clks per bit.
// Latency: n/a.
// Backpressure: n/a.
module tb_picture_sender;

    localparam int H        = 2;
    localparam int V        = 2;
    localparam int CF       = 4;
    localparam int BR       = 1;
    localparam int CPB      = CF / BR;
    localparam int NPIX     = H * V;
    localparam int FRAME    = 10 * CPB;
    localparam int EXP_BUSY = 3 * NPIX * FRAME + 4 * NPIX;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [18:0] rd_addr;
    logic [17:0] rd_data;
    logic        uart_tx;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    picture_sender #(
        .H_SIZE    (H),
        .V_SIZE    (V),
        .CLK_FREQ  (CF),
        .BAUD_RATE (BR)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .uart_tx (uart_tx),
        .busy    (busy),
        .done    (done)
    );

    logic [17:0] mem [4];
    always @(posedge clk)
        rd_data <= (rd_addr < 19'd4) ? mem[rd_addr[1:0]] : 18'h0;

    typedef struct {
        logic [71:0] pix;
        logic [95:0] exp;
        int          extra_at;
    } vec_t;

    vec_t       tbl [3];
    int         checks   = 0;
    int         failures = 0;
    bit         trace [$];
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int         fstart_q [$];
    int         busy_cnt, done_cnt, done_cyc, max_addr, frame_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: each pixel yields R, G, B bytes, each channel shifted up by two.
    task automatic build_model;
        logic [17:0] p;
        exp_q.delete();
        for (int a = 0; a < NPIX; a++) begin
            p = mem[a];
            exp_q.push_back({p[17:12], 2'b00});
            exp_q.push_back({p[11:6], 2'b00});
            exp_q.push_back({p[5:0], 2'b00});
        end
    endtask

    task automatic run_transfer(input bit extra, input int extra_at);
        trace.delete();
        busy_cnt = 0; done_cnt = 0; done_cyc = -1; max_addr = 0;
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 900; c++) begin
            @(negedge clk);
            start = extra && (c == extra_at);
            trace.push_back(uart_tx);
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = c; end
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            if (done_cnt > 0 && c >= done_cyc + 8) break;
        end
        start = 1'b0;
    endtask

    // Slice the per-clk line trace into frames; every bit must be CPB clks of a constant level.
    task automatic decode;
        int i;
        logic [7:0] b;
        bit ref_lvl;
        frame_err = 0;
        got_q.delete();
        fstart_q.delete();
        i = 0;
        while (i < trace.size()) begin
            if (trace[i] == 1'b0) begin
                if (i + FRAME > trace.size()) begin
                    frame_err++;
                    break;
                end
                b = 8'h00;
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < CPB; j++) begin
                        ref_lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : trace[i + k*CPB];
                        if (trace[i + k*CPB + j] != ref_lvl) frame_err++;
                    end
                    if (k >= 1 && k <= 8) b[k-1] = trace[i + k*CPB];
                end
                got_q.push_back(b);
                fstart_q.push_back(i + 1);
                i += FRAME;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_transfer(input string tag, input bit extra, input int extra_at);
        int n, inner_bad, inter_bad, gap;
        run_transfer(extra, extra_at);
        decode();
        chk($sformatf("%s nbytes", tag), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
        chk($sformatf("%s frame_timing_errs", tag), frame_err, 0);
        chk($sformatf("%s done_pulses", tag), done_cnt, 1);
        chk($sformatf("%s done_cycle", tag), done_cyc, EXP_BUSY + 1);
        chk($sformatf("%s busy_cycles", tag), busy_cnt, EXP_BUSY);
        chk($sformatf("%s first_start_cycle", tag), (fstart_q.size() > 0) ? fstart_q[0] : -1, 5);
        inner_bad = 0; inter_bad = 0;
        for (int f = 1; f < fstart_q.size(); f++) begin
            gap = fstart_q[f] - fstart_q[f-1] - FRAME;
            if (f % 3 != 0) begin
                if (gap != 0) inner_bad++;
            end else begin
                if (gap < 0 || gap > 4) inter_bad++;
            end
        end
        chk($sformatf("%s intra_pixel_gaps", tag), inner_bad, 0);
        chk($sformatf("%s inter_pixel_gaps", tag), inter_bad, 0);
        chk($sformatf("%s max_rd_addr", tag), max_addr, NPIX - 1);
    endtask

    task automatic load_vec(input int v);
        for (int a = 0; a < NPIX; a++)
            mem[a] = tbl[v].pix[(3-a)*18 +: 18];
        exp_q.delete();
        for (int i = 0; i < 12; i++)
            exp_q.push_back(tbl[v].exp[(11-i)*8 +: 8]);
    endtask

    initial begin
        int lowc, busyc, donec;
        tbl[0] = '{{18'h3FFFF, 18'h00000, 18'h15555, 18'h2AAAA}, 96'hFCFCFC_000000_545454_A8A8A8, 0};
        tbl[1] = '{{18'h3FFFF, 18'h00000, 18'h15555, 18'h2AAAA}, 96'hFCFCFC_000000_545454_A8A8A8, 200};
        tbl[2] = '{{18'h01083, 18'h00000, 18'h3F020, 18'h0A570}, 96'h04080C_000000_FC0080_2854C0, EXP_BUSY + 1};

        resetn = 1'b0;
        start  = 1'b0;
        load_vec(0);
        repeat (3) @(negedge clk);
        chk("reset uart_tx", uart_tx, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset rd_addr", rd_addr, 19'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle uart_tx", uart_tx, 1'b1);

        for (int v = 0; v < 3; v++) begin
            load_vec(v);
            check_transfer($sformatf("vec%0d", v), tbl[v].extra_at != 0, tbl[v].extra_at);
            repeat (3) @(negedge clk);
        end

        // Reset in the middle of pixel 1's G frame (a zero data bit is on the line).
        load_vec(0);
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 180; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre-reset uart_tx", uart_tx, 1'b0);
        chk("pre-reset busy", busy, 1'b1);
        resetn = 1'b0;
        #1;
        chk("midreset uart_tx", uart_tx, 1'b1);
        chk("midreset busy", busy, 1'b0);
        chk("midreset done", done, 1'b0);
        chk("midreset rd_addr", rd_addr, 19'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        lowc = 0; busyc = 0; donec = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!uart_tx) lowc++;
            if (busy) busyc++;
            if (done) donec++;
        end
        chk("post-reset line_low_clks", lowc, 0);
        chk("post-reset busy_clks", busyc, 0);
        chk("post-reset done_pulses", donec, 0);
        check_transfer("after_reset", 1'b0, 0);

        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < NPIX; a++)
                mem[a] = 18'($urandom);
            build_model();
            check_transfer($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
                           int'($urandom_range(2, EXP_BUSY + 1)));
            repeat (int'($urandom_range(1, 5))) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
